// File: rtl/zkn_sbox_arbiter.sv
// zkn_sbox_arbiter
//   Shares one fixed-latency AES S-box datapath between NR_REQ requesters
//   (index 0: core ZKN FU, index 1: CV-X-IF coprocessor). One lookup is
//   granted per cycle in round-robin order. Each issue is tagged with its
//   requester index and transaction ID in a shift pipe of depth SBOX_LAT,
//   so the S-box result is routed back to its owner when it emerges.
//   Core-side (index 0) entries are killed on pipeline flush.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   en_i                   ZKN enable; 0 blocks new grants only
//   flush_i                core flush; kills requester-0 traffic
//   req_valid_i/ready_o    per-requester handshake (ready is one-hot or zero)
//   req_data_i/inv_i/tid_i per-requester word, inverse select, transaction ID
//   sbox_valid_o/in_o/inv_o  issue to the S-box pipeline
//   sbox_out_i             S-box result for the issue SBOX_LAT cycles earlier
//   rsp_valid_o/data_o/tid_o result return (one-hot valid, no backpressure)
module zkn_sbox_arbiter #(
  parameter int unsigned NR_REQ   = 2,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TID_W    = 3,
  parameter int unsigned SBOX_LAT = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic                      flush_i,
  input  logic [NR_REQ-1:0]         req_valid_i,
  output logic [NR_REQ-1:0]         req_ready_o,
  input  logic [NR_REQ*DATA_W-1:0]  req_data_i,
  input  logic [NR_REQ-1:0]         req_inv_i,
  input  logic [NR_REQ*TID_W-1:0]   req_tid_i,
  output logic                      sbox_valid_o,
  output logic [DATA_W-1:0]         sbox_in_o,
  output logic                      sbox_inv_o,
  input  logic [DATA_W-1:0]         sbox_out_i,
  output logic [NR_REQ-1:0]         rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic [TID_W-1:0]          rsp_tid_o
);

  localparam int unsigned IDX_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam int unsigned LAST  = SBOX_LAT - 1;

  logic [NR_REQ-1:0]   w_elig;
  logic [NR_REQ-1:0]   w_gnt;
  logic [IDX_W-1:0]    w_gnt_idx;
  logic                w_any;
  logic [DATA_W-1:0]   w_sbox_in;
  logic                w_sbox_inv;
  logic [TID_W-1:0]    w_tid;

  logic [IDX_W-1:0]    r_rr;
  logic [SBOX_LAT-1:0] r_vld;
  logic [IDX_W-1:0]    r_idx [SBOX_LAT];
  logic [TID_W-1:0]    r_tid [SBOX_LAT];

  // Grants are also gated by rst_ni so every output is quiet during reset.
  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      w_elig[i] = rst_ni & en_i & req_valid_i[i] & ~((i == 0) & flush_i);
    end
  end

  // First eligible index at or after r_rr, wrapping.
  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_any     = 1'b0;
    for (int unsigned off = 0; off < NR_REQ; off++) begin
      int unsigned idx;
      idx = (32'(r_rr) + off) % NR_REQ;
      if (!w_any && w_elig[idx]) begin
        w_any      = 1'b1;
        w_gnt[idx] = 1'b1;
        w_gnt_idx  = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    w_sbox_in  = '0;
    w_sbox_inv = 1'b0;
    w_tid      = '0;
    for (int unsigned i = 0; i < NR_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sbox_in  = req_data_i[i*DATA_W +: DATA_W];
        w_sbox_inv = req_inv_i[i];
        w_tid      = req_tid_i[i*TID_W +: TID_W];
      end
    end
  end

  assign req_ready_o  = w_gnt;
  assign sbox_valid_o = w_any;
  assign sbox_in_o    = w_sbox_in;
  assign sbox_inv_o   = w_sbox_inv;

  // Flush clears requester-0 valids as they move one stage, which covers
  // both the entry being loaded and every entry still inside the pipe; the
  // last stage has already been presented and simply drops out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr  <= '0;
      r_vld <= '0;
      for (int unsigned s = 0; s < SBOX_LAT; s++) begin
        r_idx[s] <= '0;
        r_tid[s] <= '0;
      end
    end else begin
      if (w_any) begin
        r_rr <= (w_gnt_idx == IDX_W'(NR_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
      end
      r_vld[0] <= w_any & ~(flush_i & (w_gnt_idx == '0));
      r_idx[0] <= w_gnt_idx;
      r_tid[0] <= w_tid;
      for (int unsigned s = 1; s < SBOX_LAT; s++) begin
        r_vld[s] <= r_vld[s-1] & ~(flush_i & (r_idx[s-1] == '0));
        r_idx[s] <= r_idx[s-1];
        r_tid[s] <= r_tid[s-1];
      end
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    rsp_tid_o   = '0;
    if (r_vld[LAST]) begin
      for (int unsigned i = 0; i < NR_REQ; i++) begin
        if (r_idx[LAST] == IDX_W'(i)) begin
          rsp_valid_o[i] = 1'b1;
        end
      end
      rsp_data_o = sbox_out_i;
      rsp_tid_o  = r_tid[LAST];
    end
  end

endmodule

// File: tb/tb_zkn_sbox_arbiter.sv
module tb_zkn_sbox_arbiter;
  localparam int NR  = 2;
  localparam int DW  = 32;
  localparam int TW  = 3;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst_ni = 1'b0;
  logic           en_i = 1'b0;
  logic           flush_i = 1'b0;
  logic [NR-1:0]  req_valid_i = '0;
  logic [NR-1:0]  req_ready_o;
  logic [NR*DW-1:0] req_data_i = '0;
  logic [NR-1:0]  req_inv_i = '0;
  logic [NR*TW-1:0] req_tid_i = '0;
  logic           sbox_valid_o;
  logic [DW-1:0]  sbox_in_o;
  logic           sbox_inv_o;
  logic [DW-1:0]  sbox_out_i;
  logic [NR-1:0]  rsp_valid_o;
  logic [DW-1:0]  rsp_data_o;
  logic [TW-1:0]  rsp_tid_o;

  always #5 clk = ~clk;

  zkn_sbox_arbiter #(.NR_REQ(NR), .DATA_W(DW), .TID_W(TW), .SBOX_LAT(LAT)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_data_i(req_data_i), .req_inv_i(req_inv_i), .req_tid_i(req_tid_i),
    .sbox_valid_o(sbox_valid_o), .sbox_in_o(sbox_in_o), .sbox_inv_o(sbox_inv_o),
    .sbox_out_i(sbox_out_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_tid_o(rsp_tid_o)
  );

  // ---------------- AES S-box model (environment) ----------------
  logic [7:0] fwd [256];
  logic [7:0] bwd [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_tables();
    logic [7:0] x, y, iv, s;
    for (int xi = 0; xi < 256; xi++) begin
      x = 8'(xi);
      iv = 8'h00;
      for (int yi = 1; yi < 256; yi++) begin
        y = 8'(yi);
        if (gmul(x, y) == 8'h01) iv = y;
      end
      s = iv ^ rotl8(iv, 1) ^ rotl8(iv, 2) ^ rotl8(iv, 3) ^ rotl8(iv, 4) ^ 8'h63;
      fwd[xi] = s;
      bwd[s]  = x;
    end
  endtask

  function automatic logic [31:0] sbw(input logic [31:0] w, input logic inv);
    logic [31:0] r;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      r[l*8 +: 8] = inv ? bwd[w[l*8 +: 8]] : fwd[w[l*8 +: 8]];
    end
    return r;
  endfunction

  logic [32:0] bp [LAT] = '{default: '0};
  always @(posedge clk) begin
    bp[0] <= {sbox_inv_o, sbox_in_o};
    for (int s = 1; s < LAT; s++) bp[s] <= bp[s-1];
  end
  always_comb sbox_out_i = sbw(bp[LAT-1][31:0], bp[LAT-1][32]);

  // ---------------- scoreboard ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { logic [NR-1:0] rdy; logic [31:0] din; logic inv; } iss_t;
  typedef struct { int req; logic [TW-1:0] tid; logic [31:0] data; logic inv; int due; } rsp_t;
  iss_t iss_q[$];
  rsp_t rsp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // requester-side model: a pending request is held until granted
  logic          pend [NR] = '{default: 1'b0};
  logic [31:0]   pdat [NR];
  logic [TW-1:0] ptid [NR];
  logic          pinv [NR];
  int            rr_m = 0;

  task automatic post(input int i, input logic [31:0] d, input logic [TW-1:0] t, input logic v);
    pend[i] = 1'b1; pdat[i] = d; ptid[i] = t; pinv[i] = v;
  endtask

  task automatic post_rand(input int i);
    if (!pend[i]) post(i, $urandom, TW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
  endtask

  task automatic step(input logic rst, input logic en, input logic fl);
    int n, g, k;
    iss_t e;
    rsp_t r;
    rsp_t keep[$];
    @(posedge clk);
    #1;
    n = cyc;
    rst_ni = rst; en_i = en; flush_i = fl;
    for (int i = 0; i < NR; i++) begin
      req_valid_i[i] = pend[i];
      req_data_i[i*DW +: DW] = pend[i] ? pdat[i] : '0;
      req_tid_i[i*TW +: TW]  = pend[i] ? ptid[i] : '0;
      req_inv_i[i] = pend[i] ? pinv[i] : 1'b0;
    end
    g = -1;
    if (!rst) begin
      rsp_q.delete();
      rr_m = 0;
    end else begin
      for (int off = 0; off < NR; off++) begin
        k = (rr_m + off) % NR;
        if (g < 0 && pend[k] && en && !(k == 0 && fl)) g = k;
      end
      if (fl) begin
        foreach (rsp_q[j]) if (!(rsp_q[j].req == 0 && rsp_q[j].due > n)) keep.push_back(rsp_q[j]);
        rsp_q = keep;
      end
      if (g >= 0) begin
        r.req = g; r.tid = ptid[g]; r.data = pdat[g]; r.inv = pinv[g]; r.due = n + LAT;
        rsp_q.push_back(r);
        pend[g] = 1'b0;
        rr_m = (g + 1) % NR;
      end
    end
    e.rdy = (g >= 0) ? NR'(1 << g) : '0;
    e.din = (g >= 0) ? r.data : '0;
    e.inv = (g >= 0) ? r.inv : 1'b0;
    iss_q.push_back(e);
  endtask

  // monitor: compares issue side every cycle, pops a response when due
  initial begin
    iss_t e;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (iss_q.size() > 0) begin
        e = iss_q.pop_front();
        chk("req_ready", 32'(req_ready_o), 32'(e.rdy));
        chk("sbox_valid", 32'(sbox_valid_o), 32'(|e.rdy));
        chk("sbox_in", sbox_in_o, e.din);
        chk("sbox_inv", 32'(sbox_inv_o), 32'(e.inv));
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
          r = rsp_q.pop_front();
          chk("rsp_valid", 32'(rsp_valid_o), 32'(1 << r.req));
          chk("rsp_data", rsp_data_o, sbw(r.data, r.inv));
          chk("rsp_tid", 32'(rsp_tid_o), 32'(r.tid));
        end else begin
          chk("rsp_valid_idle", 32'(rsp_valid_o), 32'h0);
          chk("rsp_data_idle", rsp_data_o, 32'h0);
          chk("rsp_tid_idle", 32'(rsp_tid_o), 32'h0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    build_tables();
    // reset
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    // single request (0x00010203 -> 0x637C777B)
    post(0, 32'h00010203, 3'd5, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    // bring pointer back to 0, then contention
    post(1, 32'h0f1e2d3c, 3'd7, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 6; c++) begin
      post_rand(0); post_rand(1);
      step(1'b1, 1'b1, 1'b0);
    end
    repeat (3) step(1'b1, 1'b1, 1'b0);
    // flush kills an in-pipe requester-0 entry
    post(0, 32'h11223344, 3'd1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    post(1, 32'h55667788, 3'd2, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    // flush while requester-0 entry sits in last stage: still presented
    post(0, 32'h99aabbcc, 3'd1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    post(1, 32'hddeeff00, 3'd2, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    // flush with both valid: grant 1, pointer to 0
    post_rand(0); post_rand(1);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    // disable with an entry in flight
    post_rand(0);
    step(1'b1, 1'b1, 1'b0);
    post_rand(0); post_rand(1);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    // reset mid-flight
    post_rand(0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    // random traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) < 6) post_rand(0);
      if ($urandom_range(0, 9) < 6) post_rand(1);
      step(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 5) == 0));
    end
    repeat (LAT + 2) step(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("drain", 32'(rsp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
